otter_intr_csr_ctrl: RTL
========================

// Module: otter_intr_csr_ctrl
// PURPOSE
//  Interrupt and machine-CSR controller for the OTTER MCU. Synchronises external INTR and latches it as pending.
//  Decides trap entry at instruction boundaries; drives int_taken/mret_exec to CU_FSM and CU_DCDR.
//  Owns mstatus/mie/mtvec/mepc/mcause/mip; supplies the MTVEC/MEPC PC-mux sources and csr_RD to the datapath.
// PARAMETERS
//  SYNC_STAGES   2        flops in INTR synchroniser (>=2)
//  EDGE_TRIG     1        1: rising edge of synced INTR sets pending; 0: level (pending = synced INTR)
//  MTVEC_RST     32'h0    reset value of mtvec
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   synchronous active-high reset
//  INTR       in   1   external interrupt, asynchronous to CLK
//  instr_done in   1   1-cycle pulse from CU_FSM: current instruction retires this cycle
//  pc_next    in   32  PC of next instruction to execute (PC mux output), sampled with instr_done
//  mret_req   in   1   retiring instruction is MRET (valid with instr_done)
//  csr_we     in   1   CSR write strobe (CSRRW retiring)
//  csr_addr   in   12  CSR address, ir[31:20]
//  csr_wd     in   32  CSR write data (rs1)
//  csr_rd     out  32  CSR read data, combinational on csr_addr
//  int_taken  out  1   trap-entry cycle; CU selects pcSource=MTVEC, PCWrite=1
//  mret_exec  out  1   mret cycle; CU selects pcSource=MEPC, PCWrite=1
//  mtvec      out  32  trap vector (bits[1:0]=0)
//  mepc       out  32  return PC (bits[1:0]=0)
// BEHAVIOUR
//  - Reset: state=RUN, pending=0, synchroniser=0, mstatus.MIE=0, MPIE=0, mie.MEIE=0, mtvec=MTVEC_RST, mepc=0,
//    mcause=0; int_taken=0, mret_exec=0.
//  - Sync: INTR passes SYNC_STAGES flops; rising edge (EDGE_TRIG=1) sets pending 1 cycle after final flop.
//    Pending is cleared only in TRAP; set-and-clear in same cycle: set wins.
//  - FSM states RUN, TRAP, MRET. Outputs are Moore: int_taken=(state==TRAP), mret_exec=(state==MRET).
//  - RUN: on instr_done:
//    - if mret_req -> MRET (MRET has priority over interrupt);
//    - else if pending & MIE & MEIE -> TRAP, and latch pc_next into save_pc;
//    - else stay RUN.
//    No transition without instr_done.
//  - TRAP (1 cycle): mepc<=save_pc&~3, mcause<=32'h8000000B, MPIE<=MIE, MIE<=0, pending<=0; -> RUN.
//  - MRET (1 cycle): MIE<=MPIE, MPIE<=1; -> RUN. An interrupt pending at that point is taken at next instr_done.
//  - Latency: INTR rise to int_taken >= SYNC_STAGES+2 cycles, bounded by next instr_done.
//  - CSR map (write when csr_we, any state except TRAP/MRET where trap/mret updates win; unknown addr: rd 0, wr ignored):
//    - 0x300 mstatus: bit3 MIE, bit7 MPIE, others read 0
//    - 0x304 mie: bit11 MEIE
//    - 0x305 mtvec: wd&~3
//    - 0x341 mepc: wd&~3
//    - 0x342 mcause: full 32 bits
//    - 0x344 mip: read-only, bit11=pending
//  - csr_we with instr_done that also triggers TRAP: CSR write lands this cycle, TRAP overrides its fields next cycle.
//  - RST mid-TRAP/MRET: next cycle state=RUN, all regs at reset values; no partial update retained.
// STRUCTURE
//  - Package otter_csr_pkg:
//    - CSR address localparams (CSR_MSTATUS..CSR_MIP)
//    - MCAUSE_MEXT=32'h8000000B
//    - bit indices MIE_BIT=3, MPIE_BIT=7, MEIE_BIT=11
//    - typedef enum logic[1:0] {RUN, TRAP, MRET} intr_state_t
//  - Sub-module intr_sync: SYNC_STAGES synchroniser + rising-edge detect, output 1-cycle pulse/level.
//  - Top holds FSM, pending flag, CSR registers, read mux.
// TESTING
//  1. Reset: RST=1 two cycles -> csr_rd(0x300)=0, mtvec=MTVEC_RST, int_taken=mret_exec=0.
//  2. Masked: MIE=0, pulse INTR, 5x instr_done -> no int_taken; mip(0x344)=0x800.
//     Then write mstatus=0x8 -> int_taken at next instr_done+1.
//  3. Trap entry:
//     - Setup: mtvec=0x100, mie=0x800, mstatus=0x8.
//     - Stimulus: INTR rise, instr_done with pc_next=0x24.
//     - Expect: int_taken 1 cycle; mepc=0x24, mcause=0x8000000B, mstatus=0x80, mip=0.
//  4. MRET: after test 3, mret_req+instr_done -> mret_exec 1 cycle, mepc still 0x24, mstatus=0x88.
//  5. Simultaneous: pending & MIE with mret_req+instr_done -> MRET first, TRAP at following instr_done; mepc=new pc_next.
//  6. Reset mid-op: assert RST during TRAP cycle -> next cycle RUN, mepc=0, pending=0, int_taken=0.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, bit positions and FSM state type for the OTTER
// interrupt / machine-CSR controller.
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MCAUSE_MEXT = 32'h8000000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MEIE_BIT = 11;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2
  } intr_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/intr_sync.sv
// Multi-flop synchroniser for the asynchronous INTR line with optional
// rising-edge detection (1-cycle pulse) or pass-through level output.
module intr_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_set
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_set = EDGE_TRIG ? (r_sync[SYNC_STAGES-1] & ~r_prev) : r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/otter_intr_csr_ctrl.sv
// OTTER interrupt controller: pending latch, RUN/TRAP/MRET sequencer and the
// machine CSRs (mstatus, mie, mtvec, mepc, mcause, mip) with their read mux.
module otter_intr_csr_ctrl
  import otter_csr_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter bit          EDGE_TRIG   = 1'b1,
  parameter logic [31:0] MTVEC_RST   = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic        instr_done,
  input  logic [31:0] pc_next,
  input  logic        mret_req,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  output logic        int_taken,
  output logic        mret_exec,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  intr_state_t r_state;
  logic        r_pending;
  logic        r_mie;
  logic        r_mpie;
  logic        r_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_save_pc;
  logic        w_set;

  intr_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TRIG  (EDGE_TRIG)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_async(INTR),
    .o_set  (w_set)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= RUN;
      r_pending <= 1'b0;
      r_mie     <= 1'b0;
      r_mpie    <= 1'b0;
      r_meie    <= 1'b0;
      r_mtvec   <= {MTVEC_RST[31:2], 2'b00};
      r_mepc    <= 32'h0;
      r_mcause  <= 32'h0;
      r_save_pc <= 32'h0;
    end else begin
      // A new edge in the same cycle as the TRAP clear must not be lost.
      if (w_set) begin
        r_pending <= 1'b1;
      end else if (!EDGE_TRIG || r_state == TRAP) begin
        r_pending <= 1'b0;
      end

      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= csr_wd[MIE_BIT];
            r_mpie <= csr_wd[MPIE_BIT];
          end
          CSR_MIE:    r_meie   <= csr_wd[MEIE_BIT];
          CSR_MTVEC:  r_mtvec  <= word_align(csr_wd);
          CSR_MEPC:   r_mepc   <= word_align(csr_wd);
          CSR_MCAUSE: r_mcause <= csr_wd;
          default: ;
        endcase
      end

      // Trap/mret field updates come after the CSR write so they take precedence.
      case (r_state)
        RUN: begin
          if (instr_done) begin
            if (mret_req) begin
              r_state <= MRET;
            end else if (r_pending && r_mie && r_meie) begin
              r_state   <= TRAP;
              r_save_pc <= pc_next;
            end
          end
        end
        TRAP: begin
          r_mepc   <= word_align(r_save_pc);
          r_mcause <= MCAUSE_MEXT;
          r_mpie   <= r_mie;
          r_mie    <= 1'b0;
          r_state  <= RUN;
        end
        MRET: begin
          r_mie   <= r_mpie;
          r_mpie  <= 1'b1;
          r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    csr_rd = 32'h0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rd[MIE_BIT]  = r_mie;
        csr_rd[MPIE_BIT] = r_mpie;
      end
      CSR_MIE:    csr_rd[MEIE_BIT] = r_meie;
      CSR_MTVEC:  csr_rd = r_mtvec;
      CSR_MEPC:   csr_rd = r_mepc;
      CSR_MCAUSE: csr_rd = r_mcause;
      CSR_MIP:    csr_rd[MEIE_BIT] = r_pending;
      default:    csr_rd = 32'h0;
    endcase
  end

  assign int_taken = (r_state == TRAP);
  assign mret_exec = (r_state == MRET);
  assign mtvec     = r_mtvec;
  assign mepc      = r_mepc;

endmodule
